// File: rtl/ysyx_22040632_seq_ctrl_pkg.sv
// Shared types for the multi-cycle sequencer: state encoding, halt reasons
// and the timeout counter sizing used by the bus wait helpers.
package ysyx_22040632_RISCV_PKG;

    localparam int STATE_W = 3;
    localparam int TIMEOUT_CNT_W = 16;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 256;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH_REQ  = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_MEM_REQ    = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_HALT       = 3'd7
    } seq_state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_EBREAK  = 2'b01,
        HC_ILLEGAL = 2'b10,
        HC_BUS     = 2'b11
    } halt_code_t;

endpackage

// File: rtl/ysyx_22040632_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the sequencer (master) and
// the IFU/IDU/EXU/LSU side (slave).
interface ysyx_22040632_seq_ctrl_if;
    import ysyx_22040632_RISCV_PKG::*;

    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic               ifu_rsp_valid;
    logic               ifu_rsp_err;
    logic               ir_we;
    logic               dec_is_mem;
    logic               dec_wb_en;
    logic               dec_is_ebreak;
    logic               dec_illegal;
    logic               exu_start;
    logic               exu_done;
    logic               lsu_req_valid;
    logic               lsu_req_ready;
    logic               lsu_rsp_valid;
    logic               lsu_rsp_err;
    logic               gpr_we;
    logic               pc_we;
    logic               halted;
    logic [1:0]         halt_code;
    logic [STATE_W-1:0] state_o;
    logic [63:0]        inst_cnt;

    modport master (
        output ifu_req_valid, ir_we, exu_start, lsu_req_valid, gpr_we, pc_we,
               halted, halt_code, state_o, inst_cnt,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, dec_is_mem, dec_wb_en,
               dec_is_ebreak, dec_illegal, exu_done, lsu_req_ready, lsu_rsp_valid,
               lsu_rsp_err
    );

    modport slave (
        input  ifu_req_valid, ir_we, exu_start, lsu_req_valid, gpr_we, pc_we,
               halted, halt_code, state_o, inst_cnt,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, dec_is_mem, dec_wb_en,
               dec_is_ebreak, dec_illegal, exu_done, lsu_req_ready, lsu_rsp_valid,
               lsu_rsp_err
    );

endinterface

// File: rtl/ysyx_22040632_seq_ctrl_bus_wait.sv
// One request/response channel of the sequencer: request hold, response
// qualification and, with SEQ_CTRL_TIMEOUT_EN defined, a wait-cycle timeout.
module ysyx_22040632_bus_wait
    import ysyx_22040632_RISCV_PKG::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
`ifdef SEQ_CTRL_TIMEOUT_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic req_phase,
    input  logic wait_phase,
    input  logic req_ready,
    input  logic rsp_valid,
    input  logic rsp_err,
    output logic req_valid,
    output logic req_accept,
    output logic rsp_ok,
    output logic rsp_fail
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 2..65535");
    end

    assign req_valid  = req_phase;
    assign req_accept = req_phase & req_ready;
    assign rsp_ok     = wait_phase & rsp_valid & ~rsp_err;

`ifdef SEQ_CTRL_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] wait_cnt;
    logic                     timeout;

    // A response in the last allowed cycle beats the timeout.
    assign timeout  = wait_phase & ~rsp_valid
                    & (wait_cnt == TIMEOUT_CNT_W'(MEM_TIMEOUT - 1));
    assign rsp_fail = (wait_phase & rsp_valid & rsp_err) | timeout;

    always_ff @(posedge clk) begin
        if (rst || !wait_phase) begin
            wait_cnt <= '0;
        end else if (!rsp_valid) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign rsp_fail = wait_phase & rsp_valid & rsp_err;
`endif

endmodule

// File: rtl/ysyx_22040632_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Define SEQ_CTRL_TIMEOUT_EN to halt on a fetch/LSU response that never arrives.
module ysyx_22040632_seq_ctrl
    import ysyx_22040632_RISCV_PKG::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22040632_seq_ctrl_if.master bus
);

    seq_state_t  state_q;
    halt_code_t  halt_code_q;
    logic        mem_q;
    logic        wb_q;
    logic        exec_started_q;
    logic        halted_q;
    logic [63:0] inst_cnt_q;

    logic ifu_accept, ifu_ok, ifu_fail;
    logic lsu_accept, lsu_ok, lsu_fail;

    ysyx_22040632_bus_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fetch_wait (
`ifdef SEQ_CTRL_TIMEOUT_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .req_phase  (state_q == S_FETCH_REQ),
        .wait_phase (state_q == S_FETCH_WAIT),
        .req_ready  (bus.ifu_req_ready),
        .rsp_valid  (bus.ifu_rsp_valid),
        .rsp_err    (bus.ifu_rsp_err),
        .req_valid  (bus.ifu_req_valid),
        .req_accept (ifu_accept),
        .rsp_ok     (ifu_ok),
        .rsp_fail   (ifu_fail)
    );

    ysyx_22040632_bus_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_lsu_wait (
`ifdef SEQ_CTRL_TIMEOUT_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .req_phase  (state_q == S_MEM_REQ),
        .wait_phase (state_q == S_MEM_WAIT),
        .req_ready  (bus.lsu_req_ready),
        .rsp_valid  (bus.lsu_rsp_valid),
        .rsp_err    (bus.lsu_rsp_err),
        .req_valid  (bus.lsu_req_valid),
        .req_accept (lsu_accept),
        .rsp_ok     (lsu_ok),
        .rsp_fail   (lsu_fail)
    );

    assign bus.ir_we     = ifu_ok;
    assign bus.exu_start = (state_q == S_EXEC) & ~exec_started_q;
    assign bus.gpr_we    = (state_q == S_WB) & wb_q;
    assign bus.pc_we     = (state_q == S_WB);
    assign bus.halted    = halted_q;
    assign bus.halt_code = halt_code_q;
    assign bus.state_o   = state_q;
    assign bus.inst_cnt  = inst_cnt_q;

    // halt_code is written only on the transition into S_HALT, which is terminal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FETCH_REQ;
            halt_code_q    <= HC_NONE;
            mem_q          <= 1'b0;
            wb_q           <= 1'b0;
            exec_started_q <= 1'b0;
            halted_q       <= 1'b0;
            inst_cnt_q     <= '0;
        end else begin
            case (state_q)
                S_FETCH_REQ: begin
                    if (ifu_accept) state_q <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (ifu_fail) begin
                        state_q     <= S_HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HC_BUS;
                    end else if (ifu_ok) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    mem_q          <= bus.dec_is_mem;
                    wb_q           <= bus.dec_wb_en;
                    exec_started_q <= 1'b0;
                    if (bus.dec_illegal) begin
                        state_q     <= S_HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HC_ILLEGAL;
                    end else if (bus.dec_is_ebreak) begin
                        state_q     <= S_HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HC_EBREAK;
                        inst_cnt_q  <= inst_cnt_q + 64'd1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    exec_started_q <= 1'b1;
                    if (bus.exu_done) state_q <= mem_q ? S_MEM_REQ : S_WB;
                end
                S_MEM_REQ: begin
                    if (lsu_accept) state_q <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    if (lsu_fail) begin
                        state_q     <= S_HALT;
                        halted_q    <= 1'b1;
                        halt_code_q <= HC_BUS;
                    end else if (lsu_ok) begin
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    inst_cnt_q <= inst_cnt_q + 64'd1;
                    state_q    <= S_FETCH_REQ;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

endmodule
